bp_fe_bht_ctr: RTL and testbench

Parametrised branch history table for the FE predictor. It replaces the fixed 2-bit/gselect BHT and stores rows of n-bit saturating counters. Indexing is either gselect or gshare, chosen at elaboration time. Additional features: a runtime re-initialisation (clear) request, same-cycle read/write forwarding instead of dropping writes, and a confidence output. It sits in the FE pc-gen stage beside the BTB; reads happen in IF1, and prediction/row are valid in IF2.

---
 rtl/bp_fe_bht_ctr_pkg.sv | 18 +
 rtl/bp_fe_bht_ctr_hash.sv | 38 +++
 rtl/bp_fe_bht_ctr.sv | 125 ++++++++++++
 tb/tb_bp_fe_bht_ctr.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_bht_ctr_pkg.sv
// bp_fe_bht_ctr_pkg: shared types and helpers for the parametrised branch history table
package bp_fe_bht_ctr_pkg;

    typedef enum logic {e_bht_gselect, e_bht_gshare} bp_fe_bht_hash_e;

    typedef enum logic [1:0] {e_reset, e_clear, e_run} bp_fe_bht_state_e;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] bp_fe_sat_ctr_update(input logic [31:0] ctr, input logic taken, input int width);
        logic [31:0] max_ctr;
        max_ctr = (32'd1 << width) - 32'd1;
        return taken ? ((ctr == max_ctr) ? ctr : ctr + 32'd1) : ((ctr == '0) ? ctr : ctr - 32'd1);
    endfunction

endpackage

// File: rtl/bp_fe_bht_ctr_hash.sv
// bp_fe_bht_ctr_hash: row index and counter offset from a PC and global history
module bp_fe_bht_ctr_hash
    import bp_fe_bht_ctr_pkg::*;
#(
    parameter int vaddr_width_p      = 39,
    parameter int bht_idx_width_p    = 6,
    parameter int ghist_width_p      = 2,
    parameter int bht_row_els_p      = 4,
    parameter int bht_ignored_bits_p = 2,
    parameter int hash_mode_p        = 0,
    localparam int idx_width_lp      = bht_idx_width_p + ghist_width_p,
    localparam int off_width_lp      = safe_clog2(bht_row_els_p)
) (
    input  logic [vaddr_width_p-1:0] addr_i,
    input  logic [ghist_width_p-1:0] ghist_i,
    output logic [idx_width_lp-1:0]  idx_o,
    output logic [off_width_lp-1:0]  off_o
);

    // Bits outside the index/offset fields are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^addr_i;

    if (hash_mode_p == int'(e_bht_gshare)) begin : g_gshare
        logic [idx_width_lp-1:0] a;
        assign a = addr_i[bht_ignored_bits_p +: idx_width_lp];
        assign idx_o = a ^ idx_width_lp'(ghist_i);
    end else begin : g_gselect
        assign idx_o = {addr_i[bht_ignored_bits_p +: bht_idx_width_p], ghist_i};
    end

    if (bht_row_els_p == 1) begin : g_one_el
        assign off_o = '0;
    end else begin : g_multi_el
        assign off_o = addr_i[bht_ignored_bits_p + bht_idx_width_p +: off_width_lp];
    end

endmodule

// File: rtl/bp_fe_bht_ctr.sv
// bp_fe_bht_ctr: branch history table of n-bit saturating counters with clear, forwarding and confidence
module bp_fe_bht_ctr
    import bp_fe_bht_ctr_pkg::*;
#(
    parameter int vaddr_width_p      = 39,
    parameter int bht_idx_width_p    = 6,
    parameter int ghist_width_p      = 2,
    parameter int bht_row_els_p      = 4,
    parameter int bht_ignored_bits_p = 2,
    parameter int ctr_width_p        = 2,
    parameter int hash_mode_p        = 0,
    parameter int init_ctr_p         = 2**(ctr_width_p-1) - 1,
    localparam int idx_width_lp      = bht_idx_width_p + ghist_width_p,
    localparam int els_lp            = 2**idx_width_lp,
    localparam int row_width_lp      = ctr_width_p * bht_row_els_p,
    localparam int off_width_lp      = safe_clog2(bht_row_els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    output logic                     init_done_o,
    input  logic                     w_v_i,
    output logic                     w_ready_o,
    input  logic [vaddr_width_p-1:0] w_addr_i,
    input  logic [ghist_width_p-1:0] w_ghist_i,
    input  logic [row_width_lp-1:0]  w_row_i,
    input  logic                     w_taken_i,
    input  logic                     r_v_i,
    input  logic [vaddr_width_p-1:0] r_addr_i,
    input  logic [ghist_width_p-1:0] r_ghist_i,
    output logic [row_width_lp-1:0]  val_o,
    output logic                     pred_o,
    output logic                     conf_o
);

    bp_fe_bht_state_e        state_q, state_d;
    logic [idx_width_lp-1:0] cnt_q, cnt_d, r_idx, w_idx, mem_w_addr;
    logic [off_width_lp-1:0] r_off, w_off;
    logic [row_width_lp-1:0] w_row_upd, mem_w_data, r_row, val_q;
    logic [ctr_width_p-1:0]  r_ctr;
    logic                    mem_w_v, pred_q, conf_q;
    logic [row_width_lp-1:0] mem_q [els_lp];

    bp_fe_bht_ctr_hash #(
        .vaddr_width_p(vaddr_width_p), .bht_idx_width_p(bht_idx_width_p), .ghist_width_p(ghist_width_p),
        .bht_row_els_p(bht_row_els_p), .bht_ignored_bits_p(bht_ignored_bits_p), .hash_mode_p(hash_mode_p)
    ) r_hash (.addr_i(r_addr_i), .ghist_i(r_ghist_i), .idx_o(r_idx), .off_o(r_off));

    bp_fe_bht_ctr_hash #(
        .vaddr_width_p(vaddr_width_p), .bht_idx_width_p(bht_idx_width_p), .ghist_width_p(ghist_width_p),
        .bht_row_els_p(bht_row_els_p), .bht_ignored_bits_p(bht_ignored_bits_p), .hash_mode_p(hash_mode_p)
    ) w_hash (.addr_i(w_addr_i), .ghist_i(w_ghist_i), .idx_o(w_idx), .off_o(w_off));

    // State register; reset always returns to e_reset
    always_ff @(posedge clk_i)
        state_q <= reset_i ? e_reset : state_d;

    // Next state: sweep every row once, restart the sweep on any clear request
    always_comb begin
        state_d = state_q;
        case (state_q)
            e_reset: state_d = e_clear;
            e_clear: state_d = (!clear_i && &cnt_q) ? e_run : e_clear;
            e_run:   state_d = clear_i ? e_clear : e_run;
            default: state_d = e_reset;
        endcase
    end

    // Init row counter: counts only while clearing, restarts on clear_i
    always_ff @(posedge clk_i)
        cnt_q <= reset_i ? '0 : cnt_d;

    assign cnt_d = (state_q != e_clear || clear_i) ? '0 : cnt_q + idx_width_lp'(1);

    // FSM outputs and memory write port selection (init sweep vs. accepted update)
    always_comb begin
        init_done_o = (state_q == e_run);
        w_ready_o   = init_done_o & ~clear_i;
        mem_w_v     = (state_q == e_clear) | (w_v_i & w_ready_o);
        mem_w_addr  = (state_q == e_clear) ? cnt_q : w_idx;
        mem_w_data  = (state_q == e_clear) ? {bht_row_els_p{ctr_width_p'(init_ctr_p)}} : w_row_upd;
    end

    // Update row: bump only the addressed counter, pass the others through from the snapshot
    always_comb begin
        w_row_upd = w_row_i;
        for (int k = 0; k < bht_row_els_p; k++)
            if (off_width_lp'(k) == w_off)
                w_row_upd[k*ctr_width_p +: ctr_width_p] = ctr_width_p'(bp_fe_sat_ctr_update(
                    32'(w_row_i[k*ctr_width_p +: ctr_width_p]), w_taken_i, ctr_width_p));
    end

    // Table storage write port
    always_ff @(posedge clk_i)
        if (mem_w_v)
            mem_q[mem_w_addr] <= mem_w_data;

    // A same-cycle write to the read row wins over stale memory contents
    assign r_row = (mem_w_v && mem_w_addr == r_idx) ? mem_w_data : mem_q[r_idx];

    // Counter selected by the read offset
    always_comb begin
        r_ctr = r_row[ctr_width_p-1:0];
        for (int k = 0; k < bht_row_els_p; k++)
            if (off_width_lp'(k) == r_off)
                r_ctr = r_row[k*ctr_width_p +: ctr_width_p];
    end

    // Read output register: captures on r_v_i, holds otherwise
    always_ff @(posedge clk_i)
        if (reset_i) begin
            val_q  <= '0;
            pred_q <= 1'b0;
            conf_q <= 1'b0;
        end else if (r_v_i) begin
            val_q  <= r_row;
            pred_q <= r_ctr[ctr_width_p-1];
            conf_q <= &r_ctr | ~|r_ctr;
        end

    assign val_o  = val_q;
    assign pred_o = pred_q;
    assign conf_o = conf_q;

endmodule

// File: tb/tb_bp_fe_bht_ctr.sv
// tb_bp_fe_bht_ctr: table-driven and scoreboard bench for two BHT configurations (gselect/2-bit, gshare/3-bit)
module tb_bp_fe_bht_ctr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clear, w_v, w_taken, r_v;
    logic [15:0] w_addr, r_addr;
    logic [1:0]  w_ghist, r_ghist;
    logic [3:0]  w_row0, val0;
    logic [5:0]  w_row1, val1;
    logic        done0, done1, rdy0, rdy1, p0, p1, c0, c1;

    int checks = 0;
    int errors = 0;

    logic [3:0] m0 [64];
    logic [5:0] m1 [64];

    typedef struct {
        logic [3:0] v0; logic p0; logic c0;
        logic [5:0] v1; logic p1; logic c1;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e, last_e;
    logic r_pend = 1'b0;

    typedef struct {
        logic [15:0] addr; logic [1:0] ghist; logic taken;
        logic [3:0] row0; logic [5:0] row1; logic [3:0] exp0; logic [5:0] exp1;
    } vec_t;
    vec_t tbl [6];

    bp_fe_bht_ctr #(
        .vaddr_width_p(16), .bht_idx_width_p(4), .ghist_width_p(2), .bht_row_els_p(2),
        .bht_ignored_bits_p(2), .ctr_width_p(2), .hash_mode_p(0)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .init_done_o(done0),
        .w_v_i(w_v), .w_ready_o(rdy0), .w_addr_i(w_addr), .w_ghist_i(w_ghist), .w_row_i(w_row0), .w_taken_i(w_taken),
        .r_v_i(r_v), .r_addr_i(r_addr), .r_ghist_i(r_ghist), .val_o(val0), .pred_o(p0), .conf_o(c0)
    );

    bp_fe_bht_ctr #(
        .vaddr_width_p(16), .bht_idx_width_p(4), .ghist_width_p(2), .bht_row_els_p(2),
        .bht_ignored_bits_p(2), .ctr_width_p(3), .hash_mode_p(1)
    ) dut1 (
        .clk_i(clk), .reset_i(reset), .clear_i(clear), .init_done_o(done1),
        .w_v_i(w_v), .w_ready_o(rdy1), .w_addr_i(w_addr), .w_ghist_i(w_ghist), .w_row_i(w_row1), .w_taken_i(w_taken),
        .r_v_i(r_v), .r_addr_i(r_addr), .r_ghist_i(r_ghist), .val_o(val1), .pred_o(p1), .conf_o(c1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] idx_of(input logic [15:0] a, input logic [1:0] g, input bit gs);
        logic [5:0] ab;
        ab = a[7:2];
        return gs ? (ab ^ {4'b0000, g}) : {a[5:2], g};
    endfunction

    function automatic logic [1:0] pc0(input logic [3:0] row, input logic off);
        logic [1:0] c;
        c = off ? row[3:2] : row[1:0];
        return {c[1], (c == 2'b11 || c == 2'b00)};
    endfunction

    function automatic logic [1:0] pc1(input logic [5:0] row, input logic off);
        logic [2:0] c;
        c = off ? row[5:3] : row[2:0];
        return {c[2], (c == 3'b111 || c == 3'b000)};
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 64; i++) begin
            m0[i] = 4'b0101;
            m1[i] = 6'b011011;
        end
    endfunction

    always @(posedge clk) r_pend <= r_v;

    always @(negedge clk)
        if (r_pend) begin
            if (sb.size() == 0)
                chk("scoreboard_underflow", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("val0", val0, mon_e.v0);
                chk("pred0", p0, mon_e.p0);
                chk("conf0", c0, mon_e.c0);
                chk("val1", val1, mon_e.v1);
                chk("pred1", p1, mon_e.p1);
                chk("conf1", c1, mon_e.c1);
            end
        end

    task automatic step(input logic rv, input logic [15:0] ra, input logic [1:0] rg,
                        input logic wv, input logic [15:0] wa, input logic [1:0] wg,
                        input logic [3:0] wr0, input logic [5:0] wr1, input logic wt,
                        input logic [3:0] e0, input logic [5:0] e1);
        exp_t e;
        logic [5:0] i0, i1;
        r_v = rv; r_addr = ra; r_ghist = rg;
        w_v = wv; w_addr = wa; w_ghist = wg; w_row0 = wr0; w_row1 = wr1; w_taken = wt;
        #1;
        if (wv) begin
            chk("w_ready0", rdy0, 1);
            chk("w_ready1", rdy1, 1);
            m0[idx_of(wa, wg, 1'b0)] = e0;
            m1[idx_of(wa, wg, 1'b1)] = e1;
        end
        if (rv) begin
            i0 = idx_of(ra, rg, 1'b0);
            i1 = idx_of(ra, rg, 1'b1);
            e.v0 = m0[i0];
            {e.p0, e.c0} = pc0(m0[i0], ra[6]);
            e.v1 = m1[i1];
            {e.p1, e.c1} = pc1(m1[i1], ra[6]);
            sb.push_back(e);
            last_e = e;
        end
        @(posedge clk); #1;
        r_v = 1'b0;
        w_v = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [1:0] g);
        step(1'b1, a, g, 1'b0, 16'h0, 2'b0, 4'h0, 6'h0, 1'b0, 4'h0, 6'h0);
    endtask

    task automatic sweep(input bit gs);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] iv;
            iv = 6'(i);
            if (gs) rd({8'h00, iv, 2'b00}, 2'b00);
            else    rd({10'h000, iv[5:2], 2'b00}, iv[1:0]);
        end
    endtask

    task automatic wait_init(input int exp_n, input string nm);
        int n;
        bit early;
        n = 0;
        early = 1'b0;
        w_v = 1'b1;
        while (!done0 && n < 200) begin
            if (rdy0 || rdy1) early = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        w_v = 1'b0;
        chk({nm, "_latency"}, n, exp_n);
        chk({nm, "_no_early_accept"}, early, 0);
        chk({nm, "_done1"}, done1, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h0004, 2'b11, 1'b1, 4'b0110, 6'b111000, 4'b0111, 6'b111001};
        tbl[1] = '{16'h00B0, 2'b11, 1'b0, 4'b1100, 6'b111000, 4'b1100, 6'b111000};
        tbl[2] = '{16'h0040, 2'b00, 1'b1, 4'b1100, 6'b111000, 4'b1100, 6'b111000};
        tbl[3] = '{16'h0054, 2'b01, 1'b1, 4'b0101, 6'b011000, 4'b1001, 6'b100000};
        tbl[4] = '{16'h000C, 2'b10, 1'b0, 4'b0001, 6'b000001, 4'b0000, 6'b000000};
        tbl[5] = '{16'h00D8, 2'b00, 1'b1, 4'b1011, 6'b110101, 4'b1111, 6'b111101};

        reset = 1'b1; clear = 1'b0; w_v = 1'b0; r_v = 1'b0; w_taken = 1'b0;
        w_addr = '0; r_addr = '0; w_ghist = '0; r_ghist = '0; w_row0 = '0; w_row1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done0", done0, 0);
        chk("reset_ready0", rdy0, 0);
        chk("reset_val0", val0, 0);
        chk("reset_pred0", p0, 0);
        chk("reset_conf0", c0, 0);
        chk("reset_val1", val1, 0);
        chk("reset_conf1", c1, 0);

        reset = 1'b0;
        wait_init(65, "init");
        model_init();
        sweep(1'b0);
        sweep(1'b1);

        foreach (tbl[i])
            step(1'b0, 16'h0, 2'b0, 1'b1, tbl[i].addr, tbl[i].ghist, tbl[i].row0, tbl[i].row1,
                 tbl[i].taken, tbl[i].exp0, tbl[i].exp1);
        foreach (tbl[i])
            rd(tbl[i].addr, tbl[i].ghist);

        step(1'b1, 16'h0008, 2'b01, 1'b1, 16'h0008, 2'b01, 4'b1100, 6'b010110, 1'b1, 4'b1101, 6'b010111);
        rd(16'h0054, 2'b01);
        rd(16'h0008, 2'b01);

        repeat (4) @(posedge clk);
        #1;
        chk("hold_val0", val0, last_e.v0);
        chk("hold_pred0", p0, last_e.p0);
        chk("hold_val1", val1, last_e.v1);

        sweep(1'b1);
        sweep(1'b0);

        w_v = 1'b1;
        clear = 1'b1;
        #1;
        chk("clear_ready0", rdy0, 0);
        chk("clear_ready1", rdy1, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("clear_mid_done0", done0, 0);
        chk("clear_mid_ready0", rdy0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        wait_init(64, "clear_restart");
        model_init();
        sweep(1'b0);

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_clear_val0", val0, 0);
        chk("rst_in_clear_val1", val1, 0);
        chk("rst_in_clear_done0", done0, 0);
        reset = 1'b0;
        wait_init(65, "reset_in_clear");
        model_init();
        rd(tbl[3].addr, tbl[3].ghist);
        rd(16'h0008, 2'b01);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
